// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_unit_pkg;

  // Canonical no-op (addi x0, x0, 0) used as the payload of fault markers.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Instruction alignment: low PC bits that must be zero.
  localparam logic [1:0] IALIGN_MASK = 2'b11;

  typedef enum logic {
    StFetch = 1'b0,
    StHalt  = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb & IALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head word is read straight from storage registers.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full queue is fine when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, request issue, in-order response buffering,
// redirect/fault handling and stale-response dropping.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = 2 * XLEN + 1;

  fetch_state_e    r_state;
  logic            r_run;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;
  logic            r_mis_pend;
  logic [XLEN-1:0] r_mis_pc;

  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_deq;
  logic            w_room;
  logic            w_resp_keep;
  logic            w_misaligned;
  logic [CW-1:0]   w_out_next;
  logic            w_q_push;
  logic [EW-1:0]   w_q_din;
  logic [EW-1:0]   w_q_dout;
  logic            w_q_full;
  logic            w_q_empty;
  logic [CW-1:0]   w_q_count;
  logic [XLEN-1:0] w_pcq_dout;
  logic            w_pcq_full;
  logic            w_pcq_empty;
  logic [CW-1:0]   w_pcq_count;
  logic            w_unused;

  assign w_deq        = inst_valid && inst_ready;
  assign w_room       = (int'(r_outstanding) + int'(w_q_count)) < int'(DEPTH);
  // r_run keeps the request low until the first clock edge after reset.
  assign w_req_valid  = r_run && (r_state == StFetch) && (w_room || w_deq);
  assign w_req_fire   = w_req_valid && imem_req_ready;
  assign w_resp_keep  = imem_resp_valid && (r_drop == '0);
  assign w_misaligned = is_misaligned(redirect_pc[1:0]);
  assign w_out_next   = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = !w_q_empty;
  assign inst           = w_q_dout[EW-1 -: XLEN];
  assign inst_pc        = w_q_dout[XLEN:1];
  assign inst_fault     = w_q_dout[0];

  // Full flags and PC-queue occupancy are implied by the outstanding counter.
  assign w_unused = ^{w_q_full, w_pcq_full, w_pcq_empty, w_pcq_count};

  // Select what enters the instruction queue: pending misalign marker or a live response.
  always_comb begin
    w_q_push = 1'b0;
    w_q_din  = '0;
    if (!redirect) begin
      if (r_mis_pend) begin
        w_q_push = 1'b1;
        w_q_din  = {XLEN'(INST_NOP), r_mis_pc, 1'b1};
      end else if (w_resp_keep) begin
        w_q_push = 1'b1;
        w_q_din  = {(imem_resp_err ? XLEN'(INST_NOP) : imem_resp_data), w_pcq_dout, imem_resp_err};
      end
    end
  end

  // Control FSM with PC, outstanding/drop counters and the deferred misalign marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= StFetch;
      r_run         <= 1'b0;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_mis_pend    <= 1'b0;
      r_mis_pc      <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      r_mis_pend    <= 1'b0;
      if (redirect) begin
        r_pc   <= redirect_pc;
        // Everything still in flight after this edge belongs to the old stream.
        r_drop <= w_out_next;
        if (w_misaligned) begin
          r_state    <= StHalt;
          r_mis_pend <= 1'b1;
          r_mis_pc   <= redirect_pc;
        end else begin
          r_state <= StFetch;
        end
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + XLEN'(4);
        end
        if (imem_resp_valid) begin
          if (r_drop != '0) begin
            r_drop <= r_drop - CW'(1);
          end else if (imem_resp_err) begin
            r_state <= StHalt;
            r_drop  <= w_out_next;
          end
        end
      end
    end
  end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .i_clock (clock),
    .i_reset (reset),
    .i_flush (redirect),
    .i_push  (w_q_push),
    .i_data  (w_q_din),
    .i_pop   (w_deq),
    .o_data  (w_q_dout),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  // Request PCs in issue order; dropped responses still pop their entry.
  fetch_queue #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_q (
    .i_clock (clock),
    .i_reset (reset),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (imem_resp_valid),
    .o_data  (w_pcq_dout),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty),
    .o_count (w_pcq_count)
  );

endmodule
